// File: rtl/row_clear_ctrl.sv
// rtl/row_clear_ctrl.sv - scan a locked playfield, remove full rows, report count and score
//
// Ports:
//   Clk           - clock, all state changes on its rising edge
//   Reset         - asynchronous active-low reset
//   Start         - begin an operation on Board_in (accepted only when idle)
//   Board_in      - board snapshot, bit index = row*COLS + col, row 0 at the bottom
//   Busy          - high whenever an operation is in progress (any state but IDLE)
//   Done          - one-cycle pulse, result outputs valid
//   Board_out     - compacted board, held until the next result
//   Lines_cleared - number of full rows removed
//   Score_inc     - score increment for the operation (0/1/3/5/8)

module row_clear_ctrl #(
   parameter int ROWS = 20,
   parameter int COLS = 8
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Start,
   input  logic [ROWS*COLS-1:0]   Board_in,
   output logic                   Busy,
   output logic                   Done,
   output logic [ROWS*COLS-1:0]   Board_out,
   output logic [4:0]             Lines_cleared,
   output logic [7:0]             Score_inc
);

   localparam int W  = ROWS * COLS;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state_q;
   logic [W-1:0]    board_q;
   logic [RW-1:0]   row_q;
   logic [4:0]      count_q;

   logic            busy_q;
   logic            done_q;
   logic [W-1:0]    board_out_q;
   logic [4:0]      lines_q;
   logic [7:0]      score_q;

   logic            row_full_d;
   logic [W-1:0]    board_shift_d;
   logic [7:0]      score_d;

   assign Busy          = busy_q;
   assign Done          = done_q;
   assign Board_out     = board_out_q;
   assign Lines_cleared = lines_q;
   assign Score_inc     = score_q;

   always_comb begin
      row_full_d = &board_q[int'(row_q)*COLS +: COLS];
   end

   // Rows at or above the current index drop by one; rows below are untouched
   // and the top row fills with empty cells.
   always_comb begin
      board_shift_d = board_q;
      for (int r = 0; r < ROWS; r++) begin
         if (r >= int'(row_q)) begin
            if (r < ROWS - 1) begin
               board_shift_d[r*COLS +: COLS] = board_q[(r+1)*COLS +: COLS];
            end else begin
               board_shift_d[r*COLS +: COLS] = '0;
            end
         end
      end
   end

   // count_q is already final when the last row is scanned, so the score can
   // be latched on the same edge that enters DONE.
   always_comb begin
      case (count_q)
         5'd0:    score_d = 8'd0;
         5'd1:    score_d = 8'd1;
         5'd2:    score_d = 8'd3;
         5'd3:    score_d = 8'd5;
         default: score_d = 8'd8;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= IDLE;
         board_q     <= '0;
         row_q       <= '0;
         count_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         board_out_q <= '0;
         lines_q     <= '0;
         score_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (Start) begin
                  board_q <= Board_in;
                  row_q   <= '0;
                  count_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               if (row_full_d) begin
                  // Stay on the same index: the row shifted down into it
                  // must be examined next.
                  state_q <= SHIFT;
               end else if (row_q == LAST_ROW) begin
                  done_q      <= 1'b1;
                  board_out_q <= board_q;
                  lines_q     <= count_q;
                  score_q     <= score_d;
                  state_q     <= DONE;
               end else begin
                  row_q <= row_q + RW'(1);
               end
            end
            SHIFT: begin
               board_q <= board_shift_d;
               count_q <= count_q + 5'd1;
               state_q <= SCAN;
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_row_clear_ctrl.sv
// tb/tb_row_clear_ctrl.sv - self-checking bench for row_clear_ctrl against a row-removal model

module tb_row_clear_ctrl;

   localparam int ROWS = 20;
   localparam int COLS = 8;
   localparam int W    = ROWS * COLS;

   logic           Clk;
   logic           Reset;
   logic           Start;
   logic [W-1:0]   Board_in;
   logic           Busy;
   logic           Done;
   logic [W-1:0]   Board_out;
   logic [4:0]     Lines_cleared;
   logic [7:0]     Score_inc;

   int vectors;
   int miscompares;

   row_clear_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .Start         (Start),
      .Board_in      (Board_in),
      .Busy          (Busy),
      .Done          (Done),
      .Board_out     (Board_out),
      .Lines_cleared (Lines_cleared),
      .Score_inc     (Score_inc)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: keep every non-full row in bottom-to-top order, pad the rest with empty rows.
   function automatic void model(input logic [W-1:0] b, output logic [W-1:0] o, output int n);
      logic [COLS-1:0] kept[$];
      logic [COLS-1:0] row;
      logic [COLS-1:0] full;
      full = '1;
      for (int r = 0; r < ROWS; r++) begin
         row = b[r*COLS +: COLS];
         if (row != full) kept.push_back(row);
      end
      n = ROWS - kept.size();
      o = '0;
      for (int r = 0; r < kept.size(); r++) o[r*COLS +: COLS] = kept[r];
   endfunction

   function automatic int score_of(input int n);
      int table_s[5] = '{0, 1, 3, 5, 8};
      return table_s[(n > 4) ? 4 : n];
   endfunction

   function automatic logic [W-1:0] rand_board(input int full_pct);
      logic [W-1:0] b;
      for (int r = 0; r < ROWS; r++) begin
         if ($urandom_range(99) < full_pct) b[r*COLS +: COLS] = '1;
         else b[r*COLS +: COLS] = COLS'($urandom);
      end
      return b;
   endfunction

   // Start an operation and follow it to Done. With mid_start, a second
   // request carrying b2 is raised while the first is still scanning.
   task automatic run_op(input string tag, input logic [W-1:0] b,
                         input bit mid_start, input logic [W-1:0] b2);
      logic [W-1:0] exp_b;
      int           exp_n;
      int           cyc;
      bit           got;
      int           extra;
      model(b, exp_b, exp_n);
      @(posedge Clk); #1;
      Board_in = b;
      Start    = 1'b1;
      @(posedge Clk); #1;
      Start    = 1'b0;
      Board_in = rand_board(50);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 300) begin
         @(posedge Clk); #1;
         cyc++;
         if (mid_start && cyc == 3) begin
            Start    = 1'b1;
            Board_in = b2;
         end
         if (mid_start && cyc == 5) Start = 1'b0;
         if (Done === 1'b1) got = 1'b1;
         else chk({tag, ".busy"}, W'(Busy), W'(1));
      end
      chk({tag, ".done_seen"}, W'(got), W'(1));
      chk({tag, ".latency"}, W'(cyc), W'(ROWS + 2 * exp_n));
      chk({tag, ".board"}, Board_out, exp_b);
      chk({tag, ".lines"}, W'(Lines_cleared), W'(exp_n));
      chk({tag, ".score"}, W'(Score_inc), W'(score_of(exp_n)));
      chk({tag, ".busy_in_done"}, W'(Busy), W'(1));
      @(posedge Clk); #1;
      chk({tag, ".done_pulse"}, W'(Done), W'(0));
      chk({tag, ".idle_busy"}, W'(Busy), W'(0));
      chk({tag, ".board_held"}, Board_out, exp_b);
      if (mid_start) begin
         extra = 0;
         for (int i = 0; i < 40; i++) begin
            @(posedge Clk); #1;
            if (Done === 1'b1) extra++;
         end
         chk({tag, ".extra_done"}, W'(extra), W'(0));
      end
   endtask

   initial begin
      logic [W-1:0] b;
      int           done_cnt;
      vectors     = 0;
      miscompares = 0;
      Reset       = 1'b0;
      Start       = 1'b0;
      Board_in    = '0;
      repeat (3) @(posedge Clk);
      #1;
      chk("reset.busy", W'(Busy), W'(0));
      chk("reset.done", W'(Done), W'(0));
      chk("reset.board", Board_out, '0);
      chk("reset.lines", W'(Lines_cleared), W'(0));
      chk("reset.score", W'(Score_inc), W'(0));
      Reset = 1'b1;

      run_op("empty", '0, 1'b0, '0);

      b = '0;
      b[0 +: COLS]    = 8'hFF;
      b[COLS +: COLS] = 8'h0F;
      run_op("one_line", b, 1'b0, '0);
      chk("one_line.row0", W'(Board_out[0 +: COLS]), W'(8'h0F));
      chk("one_line.row1", W'(Board_out[COLS +: COLS]), W'(8'h00));

      b = '0;
      for (int r = 0; r < 4; r++) b[r*COLS +: COLS] = 8'hFF;
      b[4*COLS +: COLS] = 8'hAA;
      run_op("tetris", b, 1'b0, '0);
      chk("tetris.out", Board_out, W'(8'hAA));

      b = '0;
      b[19*COLS +: COLS] = 8'hFF;
      b[18*COLS +: COLS] = 8'h81;
      run_op("top_row", b, 1'b0, '0);
      chk("top_row.row18", W'(Board_out[18*COLS +: COLS]), W'(8'h81));
      chk("top_row.row19", W'(Board_out[19*COLS +: COLS]), W'(0));

      run_op("all_full", '1, 1'b0, '0);

      b = rand_board(30);
      run_op("mid_start", b, 1'b1, ~b);

      for (int k = 0; k < 12; k++) begin
         run_op($sformatf("rand%0d", k), rand_board((k % 4) * 25), 1'b0, '0);
      end

      // Reset while shifting: rows 0 and 1 full, so the edge after the first
      // scan enters SHIFT.
      b = '0;
      b[0 +: COLS]      = 8'hFF;
      b[COLS +: COLS]   = 8'hFF;
      b[2*COLS +: COLS] = 8'h3C;
      @(posedge Clk); #1;
      Board_in = b;
      Start    = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      @(posedge Clk); #1;
      Reset = 1'b0;
      #1;
      chk("rst_mid.busy", W'(Busy), W'(0));
      chk("rst_mid.done", W'(Done), W'(0));
      chk("rst_mid.board", Board_out, '0);
      chk("rst_mid.lines", W'(Lines_cleared), W'(0));
      chk("rst_mid.score", W'(Score_inc), W'(0));
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge Clk); #1;
         if (Done === 1'b1) done_cnt++;
      end
      chk("rst_mid.no_done", W'(done_cnt), W'(0));
      chk("rst_mid.idle", W'(Busy), W'(0));
      run_op("after_reset", b, 1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/row_clear_ctrl.md
ROW_CLEAR_CTRL -- requirements
Module: row_clear_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 20: number of playfield rows.
REQ-002 SHALL have parameter COLS, default 8: cells per row; bit index = row*COLS + col, row 0 = bottom.
REQ-003 SHALL have port Clk, input, 1: the single clock; all state changes on posedge Clk.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-low reset; Reset=0 forces reset state immediately, independent of Clk.
REQ-005 SHALL have port Start, input, 1: request to scan and compact Board_in; sampled only in IDLE.
REQ-006 SHALL have port Board_in, input, ROWS*COLS: board snapshot after piece lock; sampled only on the Start-accept edge.
REQ-007 SHALL have port Busy, output, 1: high in every state except IDLE.
REQ-008 SHALL have port Done, output, 1: one-cycle pulse; Board_out, Lines_cleared and Score_inc are valid.
REQ-009 SHALL have port Board_out, output, ROWS*COLS: compacted board, held until the next Start accept.
REQ-010 SHALL have port Lines_cleared, output, 5: number of full rows removed in the last operation.
REQ-011 SHALL have port Score_inc, output, 8: score increment for the last operation.

Function
REQ-012 SHALL implement a four-state FSM: IDLE, SCAN, SHIFT, DONE.
REQ-013 IDLE: Start=1 at a clock edge SHALL load Board_in into the working board, set row index to 0 and line count to 0, and go to SCAN; Start=0 keeps IDLE.
REQ-014 SCAN: row full (all COLS bits 1) SHALL go to SHIFT without changing the row index.
REQ-015 SCAN: row not full and row index < ROWS-1 SHALL increment the row index and stay in SCAN.
REQ-016 SCAN: row not full and row index = ROWS-1 SHALL go to DONE.
REQ-017 SHIFT SHALL, in one edge, copy each row r+1 into row r for r = index..ROWS-2, clear row ROWS-1 to 0, increment the line count, and return to SCAN at the same index.
REQ-018 Rows below the current index SHALL never be modified.
REQ-019 DONE SHALL assert Done for exactly one cycle, drive the final board and count onto the outputs, and go to IDLE on the next edge.
REQ-020 Latency from the Start-accept edge to the cycle Done is high SHALL be exactly ROWS + 2*N cycles, where N is the number of rows cleared.
REQ-021 Start SHALL be ignored in SCAN, SHIFT and DONE; Board_in changes after acceptance SHALL have no effect.
REQ-022 Line count SHALL be 5 bits and SHALL NOT wrap for N <= ROWS.
REQ-023 Score_inc SHALL be 0, 1, 3, 5 or 8 for N = 0, 1, 2, 3 or >=4 respectively.
REQ-024 A full top row (index ROWS-1) SHALL be cleared via SHIFT and then rescanned as empty.
REQ-025 If every row is full, the result SHALL be an empty board with N = ROWS.

Reset
REQ-026 Reset=0 SHALL put the FSM in IDLE with Busy=0, Done=0, Board_out=0, Lines_cleared=0 and Score_inc=0, including when asserted mid-SCAN or mid-SHIFT.
REQ-027 After Reset returns to 1, the block SHALL require a new Start; no partial result is ever signalled with Done.

Verification
REQ-028 The bench SHALL drive an empty board then Start -> Done exactly 20 cycles after accept, Board_out=0, Lines_cleared=0, Score_inc=0.
REQ-029 The bench SHALL drive row0=0xFF, row1=0x0F, other rows 0 -> Done at 22 cycles, row0=0x0F, row1=0x00, Lines_cleared=1, Score_inc=1.
REQ-030 The bench SHALL drive rows0-3=0xFF, row4=0xAA -> Done at 28 cycles, row0=0xAA, rows1-19=0, Lines_cleared=4, Score_inc=8.
REQ-031 The bench SHALL drive row19=0xFF, row18=0x81 -> Done at 22 cycles, row18=0x81, row19=0, Lines_cleared=1.
REQ-032 The bench SHALL pulse Start again mid-SCAN with a different Board_in -> request ignored, result matches the first board, only one Done.
REQ-033 The bench SHALL assert Reset=0 during SHIFT of a 2-full-row board -> outputs zero immediately, no Done; a fresh Start then completes normally.
